// File: rtl/serial_adder_ctrl_if.sv
// Operand request and result handshake bundle for serial_adder_ctrl.
// The master side supplies operands and consumes results; the slave is the controller.
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             res_ovf;

  modport master (
    output in_valid, op_a, op_b, op_cin, out_ready,
    input  in_ready, out_valid, res_sum, res_cout, res_ovf
  );

  modport slave (
    input  in_valid, op_a, op_b, op_cin, out_ready,
    output in_ready, out_valid, res_sum, res_cout, res_ovf
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: streams operand bit pairs LSB first through one
// external full-adder cell and collects sum, carry-out and signed overflow.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_adder_ctrl_if.slave   bus,
  output logic                 fa_in1,
  output logic                 fa_in2,
  output logic                 fa_cin,
  input  logic                 fa_sum,
  input  logic                 fa_cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             cout_q;
  logic             ovf_q;

  // On the last bit, carry still holds the carry into the MSB, so overflow is carry ^ fa_cout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh  <= bus.op_a;
            b_sh  <= bus.op_b;
            carry <= bus.op_cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]};
          carry  <= fa_cout;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          if (cnt == LAST) begin
            cout_q <= fa_cout;
            ovf_q  <= carry ^ fa_cout;
            state  <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.res_sum   = sum_sh;
  assign bus.res_cout  = cout_q;
  assign bus.res_ovf   = ovf_q;

  assign fa_in1 = (state == RUN) & a_sh[0];
  assign fa_in2 = (state == RUN) & b_sh[0];
  assign fa_cin = (state == RUN) & carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: WIDTH=8 vectors and corner sequences,
// plus an exhaustive WIDTH=4 back-to-back sweep against an arithmetic model.
module tb_serial_adder_ctrl;

  logic clk;
  logic rst_n;

  serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_adder_ctrl_if #(.WIDTH(4)) bus4 ();

  logic fa8_in1, fa8_in2, fa8_cin, fa8_sum, fa8_cout;
  logic fa4_in1, fa4_in2, fa4_cin, fa4_sum, fa4_cout;

  // Reference full-adder cells wired to each controller.
  assign fa8_sum  = fa8_in1 ^ fa8_in2 ^ fa8_cin;
  assign fa8_cout = (fa8_in1 & fa8_in2) | (fa8_in1 & fa8_cin) | (fa8_in2 & fa8_cin);
  assign fa4_sum  = fa4_in1 ^ fa4_in2 ^ fa4_cin;
  assign fa4_cout = (fa4_in1 & fa4_in2) | (fa4_in1 & fa4_cin) | (fa4_in2 & fa4_cin);

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8.slave),
    .fa_in1(fa8_in1), .fa_in2(fa8_in2), .fa_cin(fa8_cin),
    .fa_sum(fa8_sum), .fa_cout(fa8_cout)
  );

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave),
    .fa_in1(fa4_in1), .fa_in2(fa4_in2), .fa_cin(fa4_cin),
    .fa_sum(fa4_sum), .fa_cout(fa4_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs[6];
  int   num_compared;
  int   num_mismatched;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    num_compared++;
    if (actual !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Waits for in_ready, presents operands for one accepting edge, then drops in_valid at the next negedge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic cin);
    int k;
    k = 0;
    while (!bus8.in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("in_ready_before_accept", 32'(bus8.in_ready), 32'd1);
    bus8.op_a     = a;
    bus8.op_b     = b;
    bus8.op_cin   = cin;
    bus8.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus8.in_valid = 1'b0;
  endtask

  // Counts negedges after the accept edge until out_valid rises.
  task automatic waitDone8(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus8.out_valid) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) checkOutput("done_timeout", 32'(bus8.out_valid), 32'd1);
  endtask

  task automatic releaseResult8();
    bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.out_ready = 1'b0;
    checkOutput("in_ready_after_release", 32'(bus8.in_ready), 32'd1);
    checkOutput("out_valid_after_release", 32'(bus8.out_valid), 32'd0);
  endtask

  task automatic runVector(input vec_t v);
    int lat;
    applyStimulus(v.a, v.b, v.cin);
    waitDone8(lat);
    checkOutput("latency", 32'(lat), 32'd8);
    checkOutput("res_sum", 32'(bus8.res_sum), 32'(v.sum));
    checkOutput("res_cout", 32'(bus8.res_cout), 32'(v.cout));
    checkOutput("res_ovf", 32'(bus8.res_ovf), 32'(v.ovf));
    releaseResult8();
  endtask

  initial begin
    int  lat;
    bit  saw_valid;
    logic [8:0] idx;
    logic [3:0] a4, b4, exp_sum4;
    logic       c4, exp_cout4, exp_ovf4;
    logic [4:0] full4;

    num_compared   = 0;
    num_mismatched = 0;

    vecs[0] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, sum: 8'h10, cout: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
    vecs[3] = '{a: 8'h80, b: 8'h80, cin: 1'b1, sum: 8'h01, cout: 1'b1, ovf: 1'b1};
    vecs[4] = '{a: 8'hA5, b: 8'h5A, cin: 1'b1, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[5] = '{a: 8'h55, b: 8'h0A, cin: 1'b0, sum: 8'h5F, cout: 1'b0, ovf: 1'b0};

    rst_n = 1'b0;
    bus8.in_valid = 1'b0; bus8.op_a = '0; bus8.op_b = '0; bus8.op_cin = 1'b0; bus8.out_ready = 1'b0;
    bus4.in_valid = 1'b0; bus4.op_a = '0; bus4.op_b = '0; bus4.op_cin = 1'b0; bus4.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("reset_in_ready", 32'(bus8.in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(bus8.out_valid), 32'd0);
    checkOutput("reset_res", {22'd0, bus8.res_sum, bus8.res_cout, bus8.res_ovf}, 32'd0);
    checkOutput("reset_fa", {29'd0, fa8_in1, fa8_in2, fa8_cin}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) runVector(vecs[i]);

    // Result held for five cycles with out_ready low; in_valid pulses must not be captured.
    applyStimulus(8'h0F, 8'h01, 1'b0);
    waitDone8(lat);
    checkOutput("hold_latency", 32'(lat), 32'd8);
    for (int k = 0; k < 5; k++) begin
      bus8.in_valid = k[0];
      bus8.op_a     = 8'h33;
      bus8.op_b     = 8'h44;
      @(negedge clk);
      checkOutput("hold_res_sum", 32'(bus8.res_sum), 32'h10);
      checkOutput("hold_cout_ovf", {30'd0, bus8.res_cout, bus8.res_ovf}, 32'd0);
      checkOutput("hold_in_ready", 32'(bus8.in_ready), 32'd0);
      checkOutput("hold_out_valid", 32'(bus8.out_valid), 32'd1);
    end
    bus8.in_valid = 1'b0;
    releaseResult8();
    @(negedge clk);
    checkOutput("idle_no_capture", 32'(bus8.in_ready), 32'd1);

    // Asynchronous reset in the middle of RUN.
    applyStimulus(8'hFF, 8'hFF, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("run_fa_active", {29'd0, fa8_in1, fa8_in2, fa8_cin}, 32'd7);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_fa", {29'd0, fa8_in1, fa8_in2, fa8_cin}, 32'd0);
    checkOutput("abort_in_ready", 32'(bus8.in_ready), 32'd1);
    checkOutput("abort_out_valid", 32'(bus8.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus8.out_valid) saw_valid = 1'b1;
    end
    checkOutput("abort_no_valid", 32'(saw_valid), 32'd0);
    runVector('{a: 8'h01, b: 8'h01, cin: 1'b0, sum: 8'h02, cout: 1'b0, ovf: 1'b0});

    // Exhaustive WIDTH=4 sweep with out_ready held high.
    for (int i = 0; i < 512; i++) begin
      idx  = 9'(i);
      a4   = idx[8:5];
      b4   = idx[4:1];
      c4   = idx[0];
      full4     = {1'b0, a4} + {1'b0, b4} + {4'd0, c4};
      exp_sum4  = full4[3:0];
      exp_cout4 = full4[4];
      exp_ovf4  = (a4[3] == b4[3]) && (exp_sum4[3] != a4[3]);
      lat = 0;
      while (!bus4.in_ready && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      bus4.op_a     = a4;
      bus4.op_b     = b4;
      bus4.op_cin   = c4;
      bus4.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus4.in_valid = 1'b0;
      lat = 0;
      for (int k = 1; k <= 12; k++) begin
        @(negedge clk);
        if (bus4.out_valid) begin
          lat = k;
          break;
        end
      end
      checkOutput("w4_latency", 32'(lat), 32'd4);
      checkOutput("w4_result", {26'd0, bus4.res_sum, bus4.res_cout, bus4.res_ovf},
                  {26'd0, exp_sum4, exp_cout4, exp_ovf4});
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
